rq_request_splitter: RTL

//  Upstream feeder of the 256-bit RQ gearbox. Accepts DMA commands (addr, DW length, rd/wr) plus a packed 256-bit write-data

---
 rtl/rq_pkg.sv | 53 +++++
 rtl/rq_tlp_sizer.sv | 36 +++
 rtl/rq_request_splitter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/rq_pkg.sv
// Shared definitions for the RQ request splitter: request type codes,
// descriptor field offsets, FSM state encoding and a descriptor builder.
// No ports; imported by rq_tlp_sizer and rq_request_splitter.
package rq_pkg;

  localparam logic [3:0] REQ_MEM_RD = 4'b0000;
  localparam logic [3:0] REQ_MEM_WR = 4'b0001;

  // Descriptor field offsets (128-bit descriptor)
  localparam int DESC_ADDR_LSB = 2;
  localparam int DESC_ADDR_MSB = 63;
  localparam int DESC_DW_LSB   = 64;
  localparam int DESC_DW_MSB   = 74;
  localparam int DESC_TYPE_LSB = 75;
  localparam int DESC_TYPE_MSB = 78;
  localparam int DESC_RID_LSB  = 80;
  localparam int DESC_RID_MSB  = 95;
  localparam int DESC_TAG_LSB  = 96;
  localparam int DESC_TAG_MSB  = 103;
  localparam int DESC_LBE_LSB  = 104;
  localparam int DESC_LBE_MSB  = 107;
  localparam int DESC_FBE_LSB  = 108;
  localparam int DESC_FBE_MSB  = 111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAN    = 2'd1,
    ST_WR_DATA = 2'd2,
    ST_RD_REQ  = 2'd3
  } rq_state_t;

  // Builds a full descriptor; unnamed bits ([1:0], [79], [127:112]) stay zero.
  // A single-DW request has no last DW, so its last byte enable is 0.
  function automatic logic [127:0] build_desc(
    input logic [61:0] addr_dw,
    input logic [10:0] tlp_dw,
    input logic        is_write,
    input logic [15:0] requester_id,
    input logic [7:0]  tag
  );
    logic [127:0] d;
    d = '0;
    d[DESC_ADDR_MSB:DESC_ADDR_LSB] = addr_dw;
    d[DESC_DW_MSB:DESC_DW_LSB]     = tlp_dw;
    d[DESC_TYPE_MSB:DESC_TYPE_LSB] = is_write ? REQ_MEM_WR : REQ_MEM_RD;
    d[DESC_RID_MSB:DESC_RID_LSB]   = requester_id;
    d[DESC_TAG_MSB:DESC_TAG_LSB]   = tag;
    d[DESC_LBE_MSB:DESC_LBE_LSB]   = (tlp_dw == 11'd1) ? 4'h0 : 4'hF;
    d[DESC_FBE_MSB:DESC_FBE_LSB]   = 4'hF;
    return d;
  endfunction

endpackage

// File: rtl/rq_tlp_sizer.sv
// Purpose: size of the next TLP = min(remaining DWs, MPS/MRRS limit, DWs to next 4KB boundary).
// Latency: purely combinational; the caller registers the result.
// Backpressure: none (no handshake).
// Ports: is_write selects MPS vs MRRS; rem_dw = DWs left in the command;
//        addr_dw_off = address bits [11:2]; tlp_dw = DWs in this TLP; beats = ceil(tlp_dw/8).
module rq_tlp_sizer
  import rq_pkg::*;
#(
  parameter int MPS_BYTES  = 256,
  parameter int MRRS_BYTES = 512
) (
  input  logic        is_write,
  input  logic [17:0] rem_dw,
  input  logic [9:0]  addr_dw_off,
  output logic [10:0] tlp_dw,
  output logic [7:0]  beats
);

  localparam logic [10:0] MPS_DW  = 11'(MPS_BYTES / 4);
  localparam logic [10:0] MRRS_DW = 11'(MRRS_BYTES / 4);

  logic [10:0] limit_dw;
  logic [10:0] bound_dw;
  logic [10:0] cap_dw;

  always_comb begin
    limit_dw = is_write ? MPS_DW : MRRS_DW;
    // Distance to the next 4KB boundary in DWs: 1..1024
    bound_dw = 11'd1024 - {1'b0, addr_dw_off};
    cap_dw   = (bound_dw < limit_dw) ? bound_dw : limit_dw;
    tlp_dw   = (rem_dw < {7'd0, cap_dw}) ? rem_dw[10:0] : cap_dw;
    // Eight DWs per 256-bit beat; a partial final beat still costs a beat
    beats    = tlp_dw[10:3] + {7'd0, |tlp_dw[2:0]};
  end

endmodule

// File: rtl/rq_request_splitter.sv
// Purpose: splits DMA commands into PCIe MemRd/MemWr TLPs bounded by MPS, MRRS and 4KB,
//          emitting a 128-bit descriptor alongside 256-bit payload beats.
// Latency: one PLAN cycle per TLP; write data passes through combinationally (0 cycles).
// Backpressure: rq_ready gates wr_ready directly; outputs hold while rq_valid && !rq_ready.
// Ports: cmd_* command handshake; wr_* packed write-data stream; rq_* descriptor/payload beats.
// Build option: define RQ_SPLIT_STATS_EN to add stat_wr_tlps/stat_rd_tlps TLP counters.
module rq_request_splitter
  import rq_pkg::*;
#(
  parameter int          MPS_BYTES    = 256,
  parameter int          MRRS_BYTES   = 512,
  parameter logic [15:0] REQUESTER_ID = 16'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_is_write,
  input  logic [63:0]  cmd_addr,
  input  logic [17:0]  cmd_len_dw,
  input  logic [255:0] wr_data,
  input  logic         wr_valid,
  output logic         wr_ready,
  output logic [127:0] rq_descriptor,
  output logic [255:0] rq_payload,
  output logic [10:0]  rq_payload_dw_count,
  output logic         rq_payload_sop,
  output logic         rq_payload_last,
  output logic         rq_valid,
  input  logic         rq_ready
`ifdef RQ_SPLIT_STATS_EN
  ,
  output logic [31:0]  stat_wr_tlps,
  output logic [31:0]  stat_rd_tlps
`endif
);

  rq_state_t   state;
  logic [63:2] addr_q;       // DW address of the next TLP
  logic [17:0] rem_q;        // DWs still to be issued for this command
  logic        is_write_q;
  logic [10:0] tlp_dw_q;
  logic [7:0]  beats_q;
  logic [7:0]  beat_idx_q;
  logic [7:0]  tag_q;

  logic [10:0] size_dw;
  logic [7:0]  size_beats;
  logic        fire;
  logic        tlp_done;

  // Byte offset within a DW is always zero for these requests
  logic        unused_addr_lsb;
  assign unused_addr_lsb = ^cmd_addr[1:0];

  rq_tlp_sizer #(
    .MPS_BYTES  (MPS_BYTES),
    .MRRS_BYTES (MRRS_BYTES)
  ) u_sizer (
    .is_write    (is_write_q),
    .rem_dw      (rem_q),
    .addr_dw_off (addr_q[11:2]),
    .tlp_dw      (size_dw),
    .beats       (size_beats)
  );

  assign rq_payload = wr_data;

  // Handshake signals are combinational so write data flows with zero latency
  always_comb begin
    rq_valid        = 1'b0;
    wr_ready        = 1'b0;
    rq_payload_sop  = 1'b0;
    rq_payload_last = 1'b0;
    case (state)
      ST_RD_REQ: begin
        rq_valid        = 1'b1;
        rq_payload_sop  = 1'b1;
        rq_payload_last = 1'b1;
      end
      ST_WR_DATA: begin
        rq_valid        = wr_valid;
        wr_ready        = rq_ready;
        rq_payload_sop  = (beat_idx_q == 8'd0);
        rq_payload_last = (beat_idx_q == beats_q - 8'd1);
      end
      default: ;
    endcase
  end

  assign fire     = rq_valid && rq_ready;
  assign tlp_done = fire && rq_payload_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= ST_IDLE;
      cmd_ready           <= 1'b1;
      addr_q              <= '0;
      rem_q               <= '0;
      is_write_q          <= 1'b0;
      tlp_dw_q            <= '0;
      beats_q             <= '0;
      beat_idx_q          <= '0;
      tag_q               <= '0;
      rq_descriptor       <= '0;
      rq_payload_dw_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q     <= cmd_addr[63:2];
            rem_q      <= cmd_len_dw;
            is_write_q <= cmd_is_write;
            // Zero-length commands are consumed without producing a TLP
            if (cmd_len_dw != 18'd0) begin
              state     <= ST_PLAN;
              cmd_ready <= 1'b0;
            end
          end
        end

        ST_PLAN: begin
          tlp_dw_q            <= size_dw;
          beats_q             <= size_beats;
          beat_idx_q          <= '0;
          rq_descriptor       <= build_desc(addr_q, size_dw, is_write_q, REQUESTER_ID, tag_q);
          rq_payload_dw_count <= is_write_q ? size_dw : 11'd0;
          state               <= is_write_q ? ST_WR_DATA : ST_RD_REQ;
        end

        ST_WR_DATA, ST_RD_REQ: begin
          if (fire && !rq_payload_last) begin
            beat_idx_q <= beat_idx_q + 8'd1;
          end
          if (tlp_done) begin
            if (state == ST_RD_REQ) begin
              tag_q <= tag_q + 8'd1;
            end
            addr_q <= addr_q + {51'd0, tlp_dw_q};
            rem_q  <= rem_q - {7'd0, tlp_dw_q};
            if (rem_q == {7'd0, tlp_dw_q}) begin
              state     <= ST_IDLE;
              cmd_ready <= 1'b1;
            end else begin
              state <= ST_PLAN;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef RQ_SPLIT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_wr_tlps <= '0;
      stat_rd_tlps <= '0;
    end else if (tlp_done) begin
      if (state == ST_WR_DATA) begin
        stat_wr_tlps <= stat_wr_tlps + 32'd1;
      end else begin
        stat_rd_tlps <= stat_rd_tlps + 32'd1;
      end
    end
  end
`endif

endmodule
